jk_seq_driver: RTL and testbench

JK_SEQ_DRIVER -- requirements
Module: jk_seq_driver

---
 rtl/jk_seq_driver.sv | 66 ++++++
 tb/tb_jk_seq_driver.sv | 108 ++++++++++
 2 files changed

// File: rtl/jk_seq_driver.sv
// jk_seq_driver: drives a byte LSB-first into an external JK flip-flop via J/K/enable excitation.
// Define JKDRV_CHECK_EN to enable settle-time feedback compare with sticky err and early abort.
module jk_seq_driver (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       q,
  output logic       ready,
  output logic       enable,
  output logic       J,
  output logic       K,
  output logic       busy,
  output logic       done,
  output logic       err
);
  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] shadow_q, shadow_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic t, accept, mismatch;
  assign t      = shadow_q[bit_idx_q];
  assign accept = (state_q == IDLE) && start;
  assign ready  = state_q == IDLE;
  assign busy   = (state_q == DRIVE) || (state_q == SETTLE);
  assign done   = state_q == DONE;
  assign enable = state_q == DRIVE;
  // J and K are mutually exclusive because t&~q and ~t&q cannot both hold
  assign J      = enable && t && !q;
  assign K      = enable && !t && q;
`ifdef JKDRV_CHECK_EN
  logic err_q, err_d;
  assign mismatch = (state_q == SETTLE) && (q != t);
  assign err      = err_q;
  always_comb begin
    err_d = accept ? 1'b0 : mismatch ? 1'b1 : err_q;
  end
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else err_q <= err_d;
  end
`else
  assign mismatch = 1'b0;
  assign err      = 1'b0;
`endif
  always_comb begin
    state_d   = (state_q == IDLE)   ? (start ? DRIVE : IDLE) :
                (state_q == DRIVE)  ? SETTLE :
                (state_q == SETTLE) ? ((bit_idx_q == 3'd7 || mismatch) ? DONE : DRIVE) :
                IDLE;
    shadow_d  = accept ? data : shadow_q;
    bit_idx_d = accept ? 3'd0 :
                (state_q == SETTLE && state_d == DRIVE) ? bit_idx_q + 3'd1 : bit_idx_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shadow_q  <= 8'h00;
      bit_idx_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      bit_idx_q <= bit_idx_d;
    end
  end
endmodule

// File: tb/tb_jk_seq_driver.sv
// tb_jk_seq_driver: directed + random byte driving against a JK flop model and a cycle-timeline reference.
module tb_jk_seq_driver;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, q;
  logic [7:0] data = 8'h00;
  logic ready, enable, J, K, busy, done, err;
  logic fq = 1'b0, stuck = 1'b1;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  assign q = fq;
  // external JK flop being driven; stuck forces Q low to model a broken flop
  always @(posedge clk)
    fq <= stuck ? 1'b0 : !enable ? fq : (J && K) ? ~fq : J ? 1'b1 : K ? 1'b0 : fq;
  jk_seq_driver dut (
    .clk(clk), .reset(reset), .start(start), .data(data), .q(q),
    .ready(ready), .enable(enable), .J(J), .K(K), .busy(busy), .done(done), .err(err)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [6:0] ctl();
    return {ready, busy, done, enable, J, K, err};
  endfunction
  // One byte: start accepted at edge n, DRIVE/SETTLE pairs in n+1..n+16, DONE n+17, IDLE n+18.
  task automatic run_byte(input logic [7:0] d, input logic [31:0] mask, input bit hold);
    logic [7:0] got;
    bit drv, t, ej, ek;
    int idx;
    got = 8'h00;
    data = d;
    start = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      start = hold | mask[k];
      data = 8'($urandom);
      idx = (k - 1) / 2;
      t = (idx < 8) ? d[idx] : 1'b0;
      drv = (k <= 16) && (k % 2 == 1);
      ej = drv && t && !fq;
      ek = drv && !t && fq;
      chk("ctl", {1'b0, ctl()}, {1'b0, 1'b0, k <= 16, k == 17, drv, ej, ek, 1'b0});
      if (k <= 16 && k % 2 == 0) begin
        chk("q_settle", {7'd0, fq}, {7'd0, t});
        got[idx] = fq;
      end
    end
    chk("byte", got, d);
    tick();
    start = hold;
    chk("idle_after", {1'b0, ctl()}, 8'b0100_0000);
  endtask
  initial begin
    start = 1'b1;
    data = 8'hFF;
    tick();
    tick();
    chk("reset", {1'b0, ctl()}, 8'b0100_0000);
    reset = 1'b0;
    start = 1'b0;
    stuck = 1'b0;
    tick();
    chk("idle", {1'b0, ctl()}, 8'b0100_0000);
    run_byte(8'hA5, 32'd0, 1'b0);
    run_byte(8'h3C, 32'h0000_0408, 1'b0);
    run_byte(8'h3C, 32'd0, 1'b0);
    data = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 7; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort", {1'b0, ctl()}, 8'b0100_0000);
    for (int k = 0; k < 18; k++) begin
      tick();
      chk("post_abort", {1'b0, ctl()}, 8'b0100_0000);
    end
`ifdef JKDRV_CHECK_EN
    stuck = 1'b1;
    data = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ck_drive", {1'b0, ctl()}, 8'b0010_1100);
    tick();
    chk("ck_settle", {1'b0, ctl()}, 8'b0010_0000);
    tick();
    chk("ck_done", {1'b0, ctl()}, 8'b0001_0001);
    tick();
    chk("ck_ready", {1'b0, ctl()}, 8'b0100_0001);
    stuck = 1'b0;
    run_byte(8'h96, 32'd0, 1'b0);
`endif
    for (int i = 0; i < 6; i++) run_byte(8'($urandom), $urandom, 1'b0);
    run_byte(8'h5A, 32'd0, 1'b1);
    run_byte(8'hC3, 32'd0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
